// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its event FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous show-ahead FIFO with a registered head; DEPTH must be a power of two.
module ps2_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_push = push & (~full | do_pop);
  assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  // NOTE: the storage array has no reset; only pointers, level and the head register do.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      // The new head is the word being written when it lands exactly at the next read slot.
      rdata <= (do_push && (wr_ptr == rd_next)) ? wdata : mem[rd_next];
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: glitch filter, 11-bit frame FSM with timeout, optional E0/F0
// prefix folding (enabled by defining PS2_RX_PREFIX_DECODE_EN) and a key-event FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_code,
  output logic                   evt_ext,
  output logic                   evt_brk,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       dat_s;

  // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_stb;

  // The filtered clock only follows after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_cnt <= '0;
        filt_clk <= clk_s;
        fall_stb <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          byte_stb;
  logic [7:0]    byte_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      byte_stb   <= 1'b0;
      byte_q     <= '0;
    end else begin
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      byte_stb   <= 1'b0;
      if ((state == ST_IDLE) || fall_stb) to_cnt <= '0;
      else                                to_cnt <= to_cnt + TW'(1);

      if ((state != ST_IDLE) && !fall_stb && (to_cnt == TO_MAX)) begin
        state     <= ST_IDLE;
        err_frame <= 1'b1;
      end else if (fall_stb) begin
        case (state)
          ST_IDLE: begin
            if (dat_s) begin
              err_frame <= 1'b1;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_s;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            // A bad stop bit outranks a parity error.
            if (!dat_s) begin
              err_frame <= 1'b1;
            end else if (!odd_parity_ok(shreg, par_bit)) begin
              err_parity <= 1'b1;
            end else begin
              byte_stb <= 1'b1;
              byte_q   <= shreg;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic     push;
  ps2_evt_t push_evt;

`ifdef PS2_RX_PREFIX_DECODE_EN
  logic ext_pend;
  logic brk_pend;
  logic is_pfx;

  assign is_pfx = (byte_q == PS2_PFX_EXT) || (byte_q == PS2_PFX_BRK);

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    push     = 1'b0;
    push_evt = '{ext: ext_pend, brk: brk_pend, code: byte_q};
    if (byte_stb && !is_pfx) push = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (err_parity || err_frame) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_stb) begin
      if (byte_q == PS2_PFX_EXT) begin
        ext_pend <= 1'b1;
      end else if (byte_q == PS2_PFX_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end
`else
  assign push     = byte_stb;
  assign push_evt = '{ext: 1'b0, brk: 1'b0, code: byte_q};
`endif

  ps2_evt_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;
  logic     ovf_evt;

  assign pop     = evt_valid & evt_ready;
  assign ovf_evt = push & fifo_full & ~pop;

  ps2_evt_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(PS2_EVT_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  (push_evt),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;

  // A fresh overflow wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n)     ovf_sticky <= 1'b0;
    else if (ovf_evt) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames in, queued expected events out.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int HALF  = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          evt_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_brk;
  logic [LW-1:0] fifo_level;
  logic          err_parity;
  logic          err_frame;
  logic          ovf_sticky;

  ps2_rx_fifo #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk),
    .fifo_level(fifo_level),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         n_par = 0;
  int         n_frm = 0;
  int         max_lvl = 0;
  logic       prev_valid = 1'b0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: error pulse counting, head-latency check and scoreboard pops.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (err_parity) n_par++;
      if (err_frame) n_frm++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (evt_valid && !prev_valid) check("valid_latency", cyc - fall_cyc, FL + 4);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL evt_unexpected: got %0h expected none", {evt_ext, evt_brk, evt_code});
        end else begin
          check("evt", {evt_ext, evt_brk, evt_code}, exp_q.pop_front());
        end
      end
    end
    prev_valid = evt_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit glitch = 1'b0, input int nbits = 11);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
    ps2_data = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 evt_ready = v;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_head"}, {evt_ext, evt_brk, evt_code}, 0);
    check({tag, "_errs"}, {err_parity, err_frame}, 0);
    check({tag, "_ovf"}, ovf_sticky, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    set_ready(1'b1);

    // Plain frame, head latency checked by the monitor.
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C);

    // Prefix sequence E0 F0 75.
    max_lvl = 0;
`ifdef PS2_RX_PREFIX_DECODE_EN
    exp_q.push_back({2'b11, 8'h75});
`else
    exp_q.push_back({2'b00, 8'hE0});
    exp_q.push_back({2'b00, 8'hF0});
    exp_q.push_back({2'b00, 8'h75});
`endif
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    wait_drain("drain_prefix");
    check("prefix_max_level", max_lvl, 1);

    // Parity error, then a good frame.
    send_frame(8'h1C, 1'b1);
    check("parity_err_cnt", n_par, 1);
    check("parity_frm_cnt", n_frm, 0);
    exp_q.push_back({2'b00, 8'h32});
    send_frame(8'h32);

    // Mid-frame timeout after 5 data bits, then a good frame.
    send_frame(8'h45, 1'b0, 1'b0, 6);
    repeat (300) @(negedge clk);
    check("timeout_frm_cnt", n_frm, 1);
    exp_q.push_back({2'b00, 8'h45});
    send_frame(8'h45);

    // Start bit of 1 is a framing error.
    ps2_bit(1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("start_frm_cnt", n_frm, 2);

    // Clock glitches shorter than the filter inside every bit.
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_drain("drain_glitch");

    // Overflow: five frames into a four-entry FIFO with the consumer stalled.
    set_ready(1'b0);
    exp_q.push_back({2'b00, 8'h16});
    exp_q.push_back({2'b00, 8'h1E});
    exp_q.push_back({2'b00, 8'h26});
    exp_q.push_back({2'b00, 8'h25});
    send_frame(8'h16);
    send_frame(8'h1E);
    send_frame(8'h26);
    send_frame(8'h25);
    send_frame(8'h2E);
    check("ovf_level", fifo_level, 4);
    check("ovf_sticky_set", ovf_sticky, 1);
    check("ovf_head", evt_code, 8'h16);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_sticky_clr", ovf_sticky, 0);
    set_ready(1'b1);
    wait_drain("drain_ovf");

    // Reset mid-frame with FIFO contents and a pending prefix.
    set_ready(1'b0);
    send_frame(8'h3C);
    send_frame(8'hE0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midreset");
    @(negedge clk);
    reset_n  = 1'b1;
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    set_ready(1'b1);
    exp_q.push_back({2'b00, 8'h4B});
    send_frame(8'h4B);
    wait_drain("drain_after_reset");

    check("final_parity_cnt", n_par, 1);
    check("final_frame_cnt", n_frm, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
